// File: rtl/ysyx_22050078_lsu_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050078_lsu_mem_bridge_pkg
// Description : Shared widths, RV64I load/store funct3 codes, bridge FSM
//               state encodings and funct3 legality helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050078_lsu_mem_bridge_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LD  = 3'b011;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_LWU = 3'b110;

    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;
    localparam logic [2:0] FUNC3_SD  = 3'b011;

    localparam logic [1:0] LSB_ST_IDLE = 2'd0;
    localparam logic [1:0] LSB_ST_REQ  = 2'd1;
    localparam logic [1:0] LSB_ST_RESP = 2'd2;
    localparam logic [1:0] LSB_ST_DONE = 2'd3;

    function automatic logic func3_legal_ld(input logic [2:0] f3);
        return (f3 != 3'b111);
    endfunction

    function automatic logic func3_legal_st(input logic [2:0] f3);
        return (f3 == FUNC3_SB) || (f3 == FUNC3_SH) ||
               (f3 == FUNC3_SW) || (f3 == FUNC3_SD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050078_lsu_mem_bridge_align.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050078_lsu_align
// Description : Combinational byte-lane alignment: store mask/data shift,
//               load shift with sign/zero extension, misalignment detect.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050078_lsu_align
    import ysyx_22050078_lsu_mem_bridge_pkg::*;
#(
    parameter int CPU_WIDTH = XLEN
) (
    input  logic [2:0]             i_func3,
    input  logic [2:0]             i_off,
    input  logic [CPU_WIDTH-1:0]   i_wdata,
    input  logic [CPU_WIDTH-1:0]   i_rdata,
    output logic [CPU_WIDTH/8-1:0] o_wmask,
    output logic [CPU_WIDTH-1:0]   o_wdata,
    output logic [CPU_WIDTH-1:0]   o_rdata,
    output logic                   o_misalign
);

    localparam int NB = CPU_WIDTH / 8;

    logic [CPU_WIDTH-1:0] w_ld_sh;
    logic [NB-1:0]        w_mask_base;

    assign w_ld_sh = i_rdata >> {i_off, 3'b000};
    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign o_wmask = w_mask_base << i_off;

    always_comb begin
        w_mask_base = NB'(8'h01);
        o_misalign  = 1'b0;
        case (i_func3[1:0])
            2'b00: begin w_mask_base = NB'(8'h01); o_misalign = 1'b0;        end
            2'b01: begin w_mask_base = NB'(8'h03); o_misalign = i_off[0];    end
            2'b10: begin w_mask_base = NB'(8'h0F); o_misalign = |i_off[1:0]; end
            2'b11: begin w_mask_base = NB'(8'hFF); o_misalign = |i_off;      end
            default: begin w_mask_base = NB'(8'h01); o_misalign = 1'b0;      end
        endcase
    end

    always_comb begin
        o_rdata = '0;
        case (i_func3)
            FUNC3_LB:  o_rdata = {{(CPU_WIDTH-8){w_ld_sh[7]}},   w_ld_sh[7:0]};
            FUNC3_LH:  o_rdata = {{(CPU_WIDTH-16){w_ld_sh[15]}}, w_ld_sh[15:0]};
            FUNC3_LW:  o_rdata = {{(CPU_WIDTH-32){w_ld_sh[31]}}, w_ld_sh[31:0]};
            FUNC3_LD:  o_rdata = w_ld_sh;
            FUNC3_LBU: o_rdata = {{(CPU_WIDTH-8){1'b0}},  w_ld_sh[7:0]};
            FUNC3_LHU: o_rdata = {{(CPU_WIDTH-16){1'b0}}, w_ld_sh[15:0]};
            FUNC3_LWU: o_rdata = {{(CPU_WIDTH-32){1'b0}}, w_ld_sh[31:0]};
            default:   o_rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050078_lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050078_lsu_mem_bridge
// Description : Multi-cycle LSU-to-memory bridge over a valid/ready bus with
//               alignment, extension, misalign detect, flush and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050078_lsu_mem_bridge
    import ysyx_22050078_lsu_mem_bridge_pkg::*;
#(
    parameter int          CPU_WIDTH = XLEN,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic                   i_ld_en,
    input  logic                   i_st_en,
    input  logic [2:0]             i_lsfunc3,
    input  logic [CPU_WIDTH-1:0]   i_addr,
    input  logic [CPU_WIDTH-1:0]   i_regst,
    input  logic                   i_flush,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CPU_WIDTH-1:0]   o_regld,
    output logic                   o_misalign,
    output logic                   o_bus_err,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic                   o_mem_we,
    output logic [CPU_WIDTH-1:0]   o_mem_addr,
    output logic [CPU_WIDTH-1:0]   o_mem_wdata,
    output logic [CPU_WIDTH/8-1:0] o_mem_wmask,
    input  logic                   i_mem_resp_valid,
    input  logic [CPU_WIDTH-1:0]   i_mem_rdata,
    input  logic                   i_mem_resp_err
);

    localparam int NB    = CPU_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]           state_q,    state_d;
    logic [CPU_WIDTH-4:0] addr_q,     addr_d;
    logic [2:0]           off_q,      off_d;
    logic [2:0]           func3_q,    func3_d;
    logic                 we_q,       we_d;
    logic [CPU_WIDTH-1:0] wdata_q,    wdata_d;
    logic [NB-1:0]        wmask_q,    wmask_d;
    logic [CPU_WIDTH-1:0] regld_q,    regld_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic                 flushed_q,  flushed_d;
    logic                 misalign_q, misalign_d;
    logic                 bus_err_q,  bus_err_d;

    logic                 w_idle;
    logic [2:0]           w_f3;
    logic [2:0]           w_off;
    logic [NB-1:0]        w_wmask;
    logic [CPU_WIDTH-1:0] w_wdata;
    logic [CPU_WIDTH-1:0] w_ld_data;
    logic                 w_misalign;
    logic                 w_is_ld;
    logic                 w_is_st;
    logic                 w_accept;
    logic                 w_timeout;
    logic                 w_kill;

    // Request-side alignment uses live inputs in IDLE; load extension uses the latched access.
    assign w_idle = (state_q == LSB_ST_IDLE);
    assign w_f3   = w_idle ? i_lsfunc3  : func3_q;
    assign w_off  = w_idle ? i_addr[2:0] : off_q;

    ysyx_22050078_lsu_align #(
        .CPU_WIDTH (CPU_WIDTH)
    ) u_align (
        .i_func3    (w_f3),
        .i_off      (w_off),
        .i_wdata    (i_regst),
        .i_rdata    (i_mem_rdata),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ld_data),
        .o_misalign (w_misalign)
    );

    assign w_is_ld   = i_ld_en;
    assign w_is_st   = i_st_en & ~i_ld_en;
    // Holding off while an error pulse is out guarantees an IDLE gap between flagged accesses.
    assign w_accept  = i_valid & ~i_flush & ~misalign_q & ~bus_err_q &
                       ((w_is_ld & func3_legal_ld(i_lsfunc3)) |
                        (w_is_st & func3_legal_st(i_lsfunc3)));
    assign w_timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign w_kill    = flushed_q | i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LSB_ST_IDLE;
            addr_q     <= '0;
            off_q      <= '0;
            func3_q    <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            regld_q    <= '0;
            cnt_q      <= '0;
            flushed_q  <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            func3_q    <= func3_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            regld_q    <= regld_d;
            cnt_q      <= cnt_d;
            flushed_q  <= flushed_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        func3_d    = func3_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        regld_d    = regld_q;
        cnt_d      = cnt_q;
        flushed_d  = flushed_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            LSB_ST_IDLE: begin
                cnt_d     = '0;
                flushed_d = 1'b0;
                if (w_accept) begin
                    addr_d  = i_addr[CPU_WIDTH-1:3];
                    off_d   = i_addr[2:0];
                    func3_d = i_lsfunc3;
                    we_d    = w_is_st;
                    wdata_d = w_is_st ? w_wdata : '0;
                    wmask_d = w_is_st ? w_wmask : '0;
                    if (w_misalign) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d = LSB_ST_REQ;
                    end
                end
            end
            LSB_ST_REQ: begin
                if (i_mem_req_ready) begin
                    // Accepted on the same edge as a flush: the request is outstanding.
                    state_d   = LSB_ST_RESP;
                    cnt_d     = '0;
                    flushed_d = i_flush;
                end else if (i_flush) begin
                    state_d = LSB_ST_IDLE;
                    cnt_d   = '0;
                end else if (w_timeout) begin
                    state_d   = LSB_ST_IDLE;
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSB_ST_RESP: begin
                if (i_mem_resp_valid) begin
                    cnt_d = '0;
                    if (w_kill) begin
                        state_d = LSB_ST_IDLE;
                    end else if (i_mem_resp_err) begin
                        state_d   = LSB_ST_IDLE;
                        bus_err_d = 1'b1;
                    end else begin
                        state_d = LSB_ST_DONE;
                        if (!we_q) begin
                            regld_d = w_ld_data;
                        end
                    end
                end else if (w_timeout) begin
                    state_d   = LSB_ST_IDLE;
                    cnt_d     = '0;
                    bus_err_d = ~w_kill;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    flushed_d = w_kill;
                end
            end
            LSB_ST_DONE: begin
                state_d = LSB_ST_IDLE;
            end
            default: begin
                state_d = LSB_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy          = (state_q != LSB_ST_IDLE);
        o_mem_req_valid = (state_q == LSB_ST_REQ);
        o_done          = (state_q == LSB_ST_DONE) & ~i_flush;
    end

    assign o_regld     = regld_q;
    assign o_misalign  = misalign_q;
    assign o_bus_err   = bus_err_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = {addr_q, 3'b000};
    assign o_mem_wdata = wdata_q;
    assign o_mem_wmask = wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050078_lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050078_lsu_mem_bridge
// Description : Directed self-checking bench for the LSU memory bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050078_lsu_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ld_en;
    logic        i_st_en;
    logic [2:0]  i_lsfunc3;
    logic [63:0] i_addr;
    logic [63:0] i_regst;
    logic        i_flush;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_regld;
    logic        o_misalign;
    logic        o_bus_err;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_resp_valid;
    logic [63:0] i_mem_rdata;
    logic        i_mem_resp_err;

    int checks   = 0;
    int failures = 0;

    ysyx_22050078_lsu_mem_bridge #(
        .CPU_WIDTH (64),
        .TIMEOUT   (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_valid          (i_valid),
        .i_ld_en          (i_ld_en),
        .i_st_en          (i_st_en),
        .i_lsfunc3        (i_lsfunc3),
        .i_addr           (i_addr),
        .i_regst          (i_regst),
        .i_flush          (i_flush),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_regld          (o_regld),
        .o_misalign       (o_misalign),
        .o_bus_err        (o_bus_err),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_we         (o_mem_we),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_wmask      (o_mem_wmask),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_rdata      (i_mem_rdata),
        .i_mem_resp_err   (i_mem_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd);
        i_valid   = 1'b1;
        i_ld_en   = ld;
        i_st_en   = st;
        i_lsfunc3 = f3;
        i_addr    = addr;
        i_regst   = wd;
    endtask

    // Load with an immediately ready bus; o_done lands on the third cycle after accept.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
        issue(1'b1, 1'b0, f3, addr, 64'h0);
        i_mem_req_ready  = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = rdata;
        step();
        i_valid = 1'b0;
        step();
        step();
        chk({tag, "_done"}, {63'h0, o_done}, 64'h1);
        chk({tag, "_data"}, o_regld, exp);
        step();
        i_mem_resp_valid = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        i_valid          = 1'b0;
        i_ld_en          = 1'b0;
        i_st_en          = 1'b0;
        i_lsfunc3        = 3'b000;
        i_addr           = 64'h0;
        i_regst          = 64'h0;
        i_flush          = 1'b0;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
        i_mem_rdata      = 64'h0;
        i_mem_resp_err   = 1'b0;

        step();
        step();
        chk("rst_busy",  {63'h0, o_busy},          64'h0);
        chk("rst_done",  {63'h0, o_done},          64'h0);
        chk("rst_reqv",  {63'h0, o_mem_req_valid}, 64'h0);
        chk("rst_regld", o_regld,                  64'h0);
        chk("rst_wmask", {56'h0, o_mem_wmask},     64'h0);
        chk("rst_addr",  o_mem_addr,               64'h0);
        rst_n = 1'b1;
        step();

        // LW with immediate ready/response
        issue(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'h0);
        i_mem_req_ready  = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = 64'h8765_4321_0000_0000;
        step();
        i_valid = 1'b0;
        chk("lw_c1_busy", {63'h0, o_busy},          64'h1);
        chk("lw_c1_reqv", {63'h0, o_mem_req_valid}, 64'h1);
        chk("lw_c1_addr", o_mem_addr,               64'h0000_0000_8000_0000);
        chk("lw_c1_we",   {63'h0, o_mem_we},        64'h0);
        chk("lw_c1_mask", {56'h0, o_mem_wmask},     64'h0);
        step();
        chk("lw_c2_done", {63'h0, o_done},          64'h0);
        chk("lw_c2_reqv", {63'h0, o_mem_req_valid}, 64'h0);
        step();
        chk("lw_c3_done", {63'h0, o_done},          64'h1);
        chk("lw_c3_busy", {63'h0, o_busy},          64'h1);
        chk("lw_c3_data", o_regld,                  64'hFFFF_FFFF_8765_4321);
        step();
        i_mem_resp_valid = 1'b0;
        chk("lw_c4_done", {63'h0, o_done}, 64'h0);
        chk("lw_c4_busy", {63'h0, o_busy}, 64'h0);

        // SB at byte 3, ready held low so the payload can be observed
        i_mem_req_ready = 1'b0;
        issue(1'b0, 1'b1, 3'b000, 64'h0000_0000_8000_0003, 64'h0000_0000_0000_00AB);
        step();
        i_valid = 1'b0;
        chk("sb_mask",  {56'h0, o_mem_wmask},     64'h08);
        chk("sb_wdata", o_mem_wdata,              64'h0000_0000_AB00_0000);
        chk("sb_addr",  o_mem_addr,               64'h0000_0000_8000_0000);
        chk("sb_we",    {63'h0, o_mem_we},        64'h1);
        step();
        chk("sb_hold_reqv", {63'h0, o_mem_req_valid}, 64'h1);
        chk("sb_hold_mask", {56'h0, o_mem_wmask},     64'h08);
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b1;
        step();
        chk("sb_done", {63'h0, o_done}, 64'h1);
        i_mem_resp_valid = 1'b0;
        step();

        // LH at byte 7: misaligned, no bus activity
        issue(1'b1, 1'b0, 3'b001, 64'h0000_0000_8000_0007, 64'h0);
        step();
        i_valid = 1'b0;
        chk("mis_pulse", {63'h0, o_misalign},      64'h1);
        chk("mis_busy",  {63'h0, o_busy},          64'h0);
        chk("mis_reqv",  {63'h0, o_mem_req_valid}, 64'h0);
        step();
        chk("mis_pulse_end", {63'h0, o_misalign},      64'h0);
        chk("mis_reqv2",     {63'h0, o_mem_req_valid}, 64'h0);

        // Illegal funct3 encodings: nothing happens
        issue(1'b1, 1'b0, 3'b111, 64'h0000_0000_8000_0000, 64'h0);
        step();
        chk("ill_ld_busy", {63'h0, o_busy},     64'h0);
        chk("ill_ld_mis",  {63'h0, o_misalign}, 64'h0);
        issue(1'b0, 1'b1, 3'b100, 64'h0000_0000_8000_0000, 64'h0);
        step();
        i_valid = 1'b0;
        chk("ill_st_busy", {63'h0, o_busy}, 64'h0);

        // Flush in REQ before acceptance
        i_mem_req_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0010, 64'h0);
        step();
        i_valid = 1'b0;
        chk("fl_c1_reqv", {63'h0, o_mem_req_valid}, 64'h1);
        step();
        i_flush = 1'b1;
        chk("fl_c2_busy", {63'h0, o_busy}, 64'h1);
        step();
        i_flush = 1'b0;
        chk("fl_idle_busy", {63'h0, o_busy},          64'h0);
        chk("fl_idle_reqv", {63'h0, o_mem_req_valid}, 64'h0);
        chk("fl_idle_done", {63'h0, o_done},          64'h0);
        step();
        step();
        do_load("ld_after_fl", 3'b011, 64'h0000_0000_8000_0020,
                64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);

        // Extension variants
        do_load("lb",  3'b000, 64'h0000_0000_8000_0005,
                64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lhu", 3'b101, 64'h0000_0000_8000_0006,
                64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
        do_load("lwu", 3'b110, 64'h0000_0000_8000_0004,
                64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        do_load("lh",  3'b001, 64'h0000_0000_8000_0002,
                64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);

        // Timeout: response never arrives, then a late response in IDLE
        issue(1'b1, 1'b0, 3'b100, 64'h0000_0000_8000_0005, 64'h0);
        i_mem_req_ready  = 1'b1;
        i_mem_resp_valid = 1'b0;
        step();
        i_valid = 1'b0;
        step();
        i_mem_req_ready = 1'b0;
        repeat (7) step();
        chk("to_c8_busy", {63'h0, o_busy},    64'h1);
        chk("to_c8_err",  {63'h0, o_bus_err}, 64'h0);
        step();
        chk("to_err",  {63'h0, o_bus_err}, 64'h1);
        chk("to_busy", {63'h0, o_busy},    64'h0);
        chk("to_done", {63'h0, o_done},    64'h0);
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        i_mem_resp_valid = 1'b0;
        chk("late_err",   {63'h0, o_bus_err}, 64'h0);
        chk("late_busy",  {63'h0, o_busy},    64'h0);
        chk("late_regld", o_regld,            64'hFFFF_FFFF_FFFF_8001);

        // Response error
        issue(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0040, 64'h0);
        i_mem_req_ready  = 1'b1;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_err   = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        step();
        i_mem_resp_valid = 1'b0;
        i_mem_resp_err   = 1'b0;
        chk("rerr_err",   {63'h0, o_bus_err}, 64'h1);
        chk("rerr_done",  {63'h0, o_done},    64'h0);
        chk("rerr_regld", o_regld,            64'hFFFF_FFFF_FFFF_8001);
        step();

        // Flush after acceptance: wait for the response silently
        issue(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0048, 64'h0);
        i_mem_req_ready = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("fresp_busy", {63'h0, o_busy}, 64'h1);
        i_mem_resp_valid = 1'b1;
        i_mem_rdata      = 64'h0123_4567_89AB_CDEF;
        step();
        i_mem_resp_valid = 1'b0;
        chk("fresp_done",  {63'h0, o_done},    64'h0);
        chk("fresp_err",   {63'h0, o_bus_err}, 64'h0);
        chk("fresp_busy2", {63'h0, o_busy},    64'h0);
        step();

        // Asynchronous reset while in RESP
        issue(1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0050, 64'h0);
        i_mem_req_ready = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        chk("ar_pre_busy", {63'h0, o_busy}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy",  {63'h0, o_busy},          64'h0);
        chk("ar_reqv",  {63'h0, o_mem_req_valid}, 64'h0);
        chk("ar_regld", o_regld,                  64'h0);
        chk("ar_addr",  o_mem_addr,               64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_post_busy", {63'h0, o_busy}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
